grid_game: RTL



---
 rtl/grid_game.sv | 124 ++++++++++++
 1 files changed

// File: rtl/grid_game.sv
// Grid maze game: a token moves over a COLS x ROWS grid of free, wall and pit cells
// until it reaches the goal, falls into a pit or runs out of its move budget.
module grid_game #(
    parameter int                   COLS      = 4,
    parameter int                   ROWS      = 4,
    parameter int                   START_X   = 0,
    parameter int                   START_Y   = 0,
    parameter int                   GOAL_X    = 3,
    parameter int                   GOAL_Y    = 3,
    parameter logic [COLS*ROWS-1:0] WALL_MASK = 16'h0002,
    parameter logic [COLS*ROWS-1:0] PIT_MASK  = 16'h0040,
    parameter int                   MAX_MOVES = 16,
    parameter int                   WRAP      = 0,
    localparam int                  XW        = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
    localparam int                  YW        = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
    localparam int                  MW        = ($clog2(MAX_MOVES + 1) > 1) ? $clog2(MAX_MOVES + 1) : 1
) (
    input  logic          clock,
    input  logic          R,
    input  logic          n,
    input  logic          s,
    input  logic          e,
    input  logic          w,
    output logic          d,
    output logic          win,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [MW-1:0] moves
);

    localparam int CW = ($clog2(COLS * ROWS) > 1) ? $clog2(COLS * ROWS) : 1;

    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_GOAL  = XW'(GOAL_X);
    localparam logic [YW-1:0] Y_GOAL  = YW'(GOAL_Y);
    localparam logic [MW-1:0] M_SAT   = {MW{1'b1}};
    localparam logic [MW-1:0] M_LIM   = MW'(MAX_MOVES);
    localparam logic          WRAP_EN = (WRAP != 0);
    localparam logic          BUDGET  = (MAX_MOVES != 0);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_DEAD = 2'd1,
        ST_WON  = 2'd2
    } state_t;

    state_t        state_q;
    logic [XW-1:0] pos_x_q, pos_x_d, tgt_x_s;
    logic [YW-1:0] pos_y_q, pos_y_d, tgt_y_s;
    logic [MW-1:0] moves_q, moves_d;
    logic          dir_ok_s, step_s, goal_s, pit_s, budget_s;

    function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        cell_idx = CW'(y) * CW'(COLS) + CW'(x);
    endfunction

    // Target cell, wall bump, and the flags that steer the FSM.
    always_comb begin
        dir_ok_s = 1'b1;
        tgt_x_s  = pos_x_q;
        tgt_y_s  = pos_y_q;
        // Edges are handled explicitly so wrap is modulo COLS/ROWS rather than 2^width.
        case ({n, s, e, w})
            4'b1000: tgt_y_s = (pos_y_q == {YW{1'b0}}) ? (WRAP_EN ? Y_MAX : pos_y_q) : pos_y_q - YW'(1);
            4'b0100: tgt_y_s = (pos_y_q == Y_MAX) ? (WRAP_EN ? {YW{1'b0}} : pos_y_q) : pos_y_q + YW'(1);
            4'b0010: tgt_x_s = (pos_x_q == X_MAX) ? (WRAP_EN ? {XW{1'b0}} : pos_x_q) : pos_x_q + XW'(1);
            4'b0001: tgt_x_s = (pos_x_q == {XW{1'b0}}) ? (WRAP_EN ? X_MAX : pos_x_q) : pos_x_q - XW'(1);
            default: dir_ok_s = 1'b0;
        endcase
        step_s = dir_ok_s && (state_q == ST_PLAY);
        if (WALL_MASK[cell_idx(tgt_x_s, tgt_y_s)]) begin
            pos_x_d = pos_x_q;
            pos_y_d = pos_y_q;
        end else begin
            pos_x_d = tgt_x_s;
            pos_y_d = tgt_y_s;
        end
        goal_s   = (pos_x_d == X_GOAL) && (pos_y_d == Y_GOAL);
        pit_s    = PIT_MASK[cell_idx(pos_x_d, pos_y_d)];
        moves_d  = (moves_q == M_SAT) ? moves_q : moves_q + MW'(1);
        budget_s = BUDGET && (moves_d == M_LIM);
    end

    // Game FSM with position and move counter; DEAD and WON hold until reset.
    always_ff @(posedge clock or posedge R) begin
        if (R) begin
            state_q <= ST_PLAY;
            pos_x_q <= X_START;
            pos_y_q <= Y_START;
            moves_q <= {MW{1'b0}};
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (step_s) begin
                        pos_x_q <= pos_x_d;
                        pos_y_q <= pos_y_d;
                        moves_q <= moves_d;
                        if (goal_s) begin
                            state_q <= ST_WON;
                        end else if (pit_s || budget_s) begin
                            state_q <= ST_DEAD;
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                ST_DEAD: state_q <= ST_DEAD;
                ST_WON:  state_q <= ST_WON;
                // An unreachable encoding ends the game rather than letting play continue.
                default: state_q <= ST_DEAD;
            endcase
        end
    end

    assign d     = (state_q == ST_DEAD);
    assign win   = (state_q == ST_WON);
    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
    assign moves = moves_q;

endmodule
